// File: rtl/gfx_pkg.sv
// Shared definitions for the orgfx fragment stage: FSM states, texel depth codes and
// the texel-index to byte-offset helper.
package gfx_pkg;

  typedef enum logic [1:0] {
    StWait    = 2'd0,
    StTexRead = 2'd1,
    StWrite   = 2'd2
  } frag_state_e;

  localparam logic [1:0] DEPTH_8  = 2'b00;
  localparam logic [1:0] DEPTH_16 = 2'b01;
  localparam logic [1:0] DEPTH_32 = 2'b11;

  // Byte offset of a texel within the texture; code 2'b10 falls through to 32bpp.
  function automatic logic [31:0] byte_offset(input logic [31:0] idx, input logic [1:0] depth);
    case (depth)
      DEPTH_8:  return idx;
      DEPTH_16: return {idx[30:0], 1'b0};
      default:  return {idx[29:0], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/gfx_texel_unpack.sv
// Texel extraction from a 32-bit read word (big-endian lanes, zero-extended) and the
// colour-key compare. The key logic exists only when GFX_FRAGMENT_COLORKEY_EN is defined;
// otherwise keyed_o is tied low and the key inputs are ignored.
module gfx_texel_unpack
  import gfx_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  depth_i,
  input  logic [1:0]  lane_i,
  input  logic        colorkey_enable_i,
  input  logic [31:0] colorkey_i,
  output logic [31:0] texel_o,
  output logic        keyed_o
);

  logic [31:0] key_mask;

  // Pick the lane for the active depth and the key bits that take part in the compare.
  always_comb begin
    texel_o  = data_i;
    key_mask = 32'hFFFF_FFFF;
    case (depth_i)
      DEPTH_8: begin
        key_mask = 32'h0000_00FF;
        case (lane_i)
          2'd0:    texel_o = {24'h0, data_i[31:24]};
          2'd1:    texel_o = {24'h0, data_i[23:16]};
          2'd2:    texel_o = {24'h0, data_i[15:8]};
          default: texel_o = {24'h0, data_i[7:0]};
        endcase
      end
      DEPTH_16: begin
        key_mask = 32'h0000_FFFF;
        texel_o  = lane_i[0] ? {16'h0, data_i[15:0]} : {16'h0, data_i[31:16]};
      end
      default: ;
    endcase
  end

`ifdef GFX_FRAGMENT_COLORKEY_EN
  assign keyed_o = colorkey_enable_i & (texel_o == (colorkey_i & key_mask));
`else
  logic unused_key;
  assign unused_key = ^{colorkey_enable_i, colorkey_i, key_mask};
  assign keyed_o    = 1'b0;
`endif

endmodule

// File: rtl/gfx_fragment.sv
// Fragment stage: captures one pixel from clip, optionally fetches its texel over the
// shared Wishbone reader, discards colour-keyed texels and hands the pixel to the blender.
// Colour keying is compiled in with GFX_FRAGMENT_COLORKEY_EN (see gfx_texel_unpack).
module gfx_fragment
  import gfx_pkg::*;
#(
  parameter int unsigned point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   texture_enable_i,
  input  logic [31:2]            tex0_base_i,
  input  logic [point_width-1:0] tex0_size_x_i,
  input  logic [point_width-1:0] tex0_size_y_i,
  input  logic [1:0]             color_depth_i,
  input  logic                   colorkey_enable_i,
  input  logic [31:0]            colorkey_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [point_width-1:0] pixel_z_i,
  input  logic [point_width-1:0] u_i,
  input  logic [point_width-1:0] v_i,
  input  logic [7:0]             a_i,
  input  logic [31:0]            color_i,
  input  logic                   write_i,
  output logic                   ack_o,
  output logic                   texture_request_o,
  output logic [31:2]            texture_addr_o,
  output logic [3:0]             texture_sel_o,
  input  logic [31:0]            texture_data_i,
  input  logic                   texture_ack_i,
  input  logic                   wbm_busy_i,
  output logic [point_width-1:0] pixel_x_o,
  output logic [point_width-1:0] pixel_y_o,
  output logic [point_width-1:0] pixel_z_o,
  output logic [7:0]             pixel_alpha_o,
  output logic [31:0]            pixel_color_o,
  output logic                   write_o,
  input  logic                   ack_i
);

  frag_state_e state_q, state_d;

  logic [point_width-1:0] px_q, px_d, py_q, py_d, pz_q, pz_d;
  logic [7:0]             alpha_q, alpha_d;
  logic [31:0]            color_q, color_d;
  logic [31:2]            addr_q, addr_d;
  logic [1:0]             lane_q, lane_d;
  logic                   req_q, req_d;
  logic                   write_q, write_d;
  logic                   ack_q, ack_d;

  logic [point_width-1:0] u_clamp, v_clamp;
  logic [31:0]            idx, offset;
  logic [31:2]            addr_new;
  logic [31:0]            texel;
  logic                   keyed;

  // Clamp to the last texel and form the word address from the incoming pixel.
  always_comb begin
    u_clamp  = (u_i >= tex0_size_x_i) ? tex0_size_x_i - point_width'(1) : u_i;
    v_clamp  = (v_i >= tex0_size_y_i) ? tex0_size_y_i - point_width'(1) : v_i;
    idx      = 32'(v_clamp) * 32'(tex0_size_x_i) + 32'(u_clamp);
    offset   = byte_offset(idx, color_depth_i);
    addr_new = tex0_base_i + offset[31:2];
  end

  gfx_texel_unpack u_unpack (
    .data_i            (texture_data_i),
    .depth_i           (color_depth_i),
    .lane_i            (lane_q),
    .colorkey_enable_i (colorkey_enable_i),
    .colorkey_i        (colorkey_i),
    .texel_o           (texel),
    .keyed_o           (keyed)
  );

  // Next-state and registered-output logic; write_o and ack_o default low to stay pulses.
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    pz_d    = pz_q;
    alpha_d = alpha_q;
    color_d = color_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    req_d   = req_q;
    write_d = 1'b0;
    ack_d   = 1'b0;
    case (state_q)
      StWait: begin
        if (write_i) begin
          px_d    = pixel_x_i;
          py_d    = pixel_y_i;
          pz_d    = pixel_z_i;
          alpha_d = a_i;
          color_d = color_i;
          addr_d  = addr_new;
          lane_d  = idx[1:0];
          if (texture_enable_i) begin
            state_d = StTexRead;
            req_d   = ~wbm_busy_i;
          end else begin
            state_d = StWrite;
            write_d = 1'b1;
          end
        end
      end
      StTexRead: begin
        if (texture_ack_i) begin
          req_d = 1'b0;
          if (keyed) begin
            state_d = StWait;
            ack_d   = 1'b1;
          end else begin
            state_d = StWrite;
            color_d = texel;
            write_d = 1'b1;
          end
        end else begin
          // Once issued, the request holds even if another client grabs the reader.
          req_d = req_q | ~wbm_busy_i;
        end
      end
      StWrite: begin
        if (ack_i) begin
          state_d = StWait;
          ack_d   = 1'b1;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StWait;
      px_q    <= '0;
      py_q    <= '0;
      pz_q    <= '0;
      alpha_q <= '0;
      color_q <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      req_q   <= 1'b0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pz_q    <= pz_d;
      alpha_q <= alpha_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      req_q   <= req_d;
      write_q <= write_d;
      ack_q   <= ack_d;
    end
  end

  assign ack_o             = ack_q;
  assign texture_request_o = req_q;
  assign texture_addr_o    = addr_q;
  assign texture_sel_o     = 4'b1111;
  assign pixel_x_o         = px_q;
  assign pixel_y_o         = py_q;
  assign pixel_z_o         = pz_q;
  assign pixel_alpha_o     = alpha_q;
  assign pixel_color_o     = color_q;
  assign write_o           = write_q;

endmodule
